// File: rtl/fetch_pkg.sv
// Shared constants and types for the RV32I instruction-fetch stage.
package fetch_pkg;

  localparam int unsigned XLEN = 32;
  localparam int unsigned ILEN = 32;

  localparam logic [ILEN-1:0] NOP_INSTR    = 32'h0000_0013;
  localparam logic [ILEN-1:0] EBREAK_INSTR = 32'h0010_0073;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_t;

  function automatic logic [XLEN-1:0] word_align(input logic [XLEN-1:0] addr);
    return {addr[XLEN-1:2], 2'b00};
  endfunction

endpackage

// File: rtl/fetch_perf_counters.sv
// Four saturating 32-bit performance counters for the fetch stage.
module fetch_perf_counters
  import fetch_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            fetch_inc,
  input  logic            stall_inc,
  input  logic            flush_inc,
  output logic [XLEN-1:0] cycle_cnt,
  output logic [XLEN-1:0] fetch_cnt,
  output logic [XLEN-1:0] stall_cnt,
  output logic [XLEN-1:0] flush_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      cycle_cnt <= '0;
      fetch_cnt <= '0;
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (cycle_cnt != '1)              cycle_cnt <= cycle_cnt + 1'b1;
      if (fetch_inc && fetch_cnt != '1) fetch_cnt <= fetch_cnt + 1'b1;
      if (stall_inc && stall_cnt != '1) stall_cnt <= stall_cnt + 1'b1;
      if (flush_inc && flush_cnt != '1) flush_cnt <= flush_cnt + 1'b1;
    end
  end

endmodule

// File: rtl/fetch_stage.sv
// IF stage: fetch PC, IF/ID register, RUN/HALT control.
// Define FETCH_PERF_CNT_EN to build the performance counters; otherwise they read 0.
module fetch_stage #(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int unsigned IMEM_DEPTH = 32,
  parameter logic [31:0] NOP_INSTR  = 32'h0000_0013
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] PCF,
  input  logic [31:0] InstrF,
  input  logic        StallF,
  input  logic        StallD,
  input  logic        FlushD,
  input  logic        PCSrcE,
  input  logic [31:0] PCTargetE,
  output logic [31:0] InstrD,
  output logic [31:0] PCD,
  output logic [31:0] PCPlus4D,
  output logic        ValidD,
  output logic        Halted,
  output logic        FetchFault,
  output logic [31:0] CycleCnt,
  output logic [31:0] FetchCnt,
  output logic [31:0] StallCnt,
  output logic [31:0] FlushCnt
);
  import fetch_pkg::*;

  fetch_state_t state;

  logic [31:0] pc_plus4;
  logic        pc_oob;
  logic        fault_take;
  logic        ebreak_take;
  logic        bubble_src;
  logic        load_valid;

  always_comb begin
    pc_plus4    = PCF + 32'd4;
    pc_oob      = {2'b00, PCF[31:2]} >= 32'(IMEM_DEPTH);
    fault_take  = (state == RUN) && pc_oob && !StallF && !PCSrcE;
    ebreak_take = (state == RUN) && !pc_oob && (InstrF == EBREAK_INSTR)
                  && !StallF && !PCSrcE && !FlushD;
    // An out-of-range word is never passed to decode, even while stalled.
    bubble_src  = (state == HALT) || pc_oob;
    load_valid  = !FlushD && !StallD && !bubble_src;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      PCF        <= RESET_PC;
      InstrD     <= NOP_INSTR;
      PCD        <= '0;
      PCPlus4D   <= '0;
      ValidD     <= 1'b0;
      state      <= RUN;
      Halted     <= 1'b0;
      FetchFault <= 1'b0;
    end else begin
      if (PCSrcE)
        PCF <= word_align(PCTargetE);
      else if (!StallF && state != HALT)
        PCF <= pc_plus4;

      // FlushD beats StallD; StallD beats the halt/fault bubble.
      if (FlushD || (!StallD && bubble_src)) begin
        InstrD   <= NOP_INSTR;
        PCD      <= '0;
        PCPlus4D <= '0;
        ValidD   <= 1'b0;
      end else if (load_valid) begin
        InstrD   <= InstrF;
        PCD      <= PCF;
        PCPlus4D <= pc_plus4;
        ValidD   <= 1'b1;
      end

      case (state)
        RUN: begin
          if (fault_take) begin
            state      <= HALT;
            Halted     <= 1'b1;
            FetchFault <= 1'b1;
          end else if (ebreak_take) begin
            state  <= HALT;
            Halted <= 1'b1;
          end
        end
        HALT: begin
          if (PCSrcE) begin
            state      <= RUN;
            Halted     <= 1'b0;
            FetchFault <= 1'b0;
          end
        end
        default: begin
          state  <= RUN;
          Halted <= 1'b0;
        end
      endcase
    end
  end

`ifdef FETCH_PERF_CNT_EN
  fetch_perf_counters u_perf (
    .clk       (clk),
    .rst       (rst),
    .fetch_inc (load_valid),
    .stall_inc (StallF && !PCSrcE),
    .flush_inc (FlushD),
    .cycle_cnt (CycleCnt),
    .fetch_cnt (FetchCnt),
    .stall_cnt (StallCnt),
    .flush_cnt (FlushCnt)
  );
`else
  assign CycleCnt = '0;
  assign FetchCnt = '0;
  assign StallCnt = '0;
  assign FlushCnt = '0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Scoreboard bench for fetch_stage: the driver queues hand-computed post-edge
// expectations, the monitor pops and compares one entry per clock edge.
module tb_fetch_stage;

  typedef struct {
    int          id;
    logic [31:0] pcf, instrd, pcd, p4;
    logic        v, h, f;
    logic        chk_cnt;
    logic [31:0] cyc, fet, stl, fls;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [31:0] PCF, InstrF, PCTargetE = '0;
  logic        StallF = 1'b0, StallD = 1'b0, FlushD = 1'b0, PCSrcE = 1'b0;
  logic [31:0] InstrD, PCD, PCPlus4D;
  logic        ValidD, Halted, FetchFault;
  logic [31:0] CycleCnt, FetchCnt, StallCnt, FlushCnt;

  logic [31:0] mem [32];
  exp_t        sb [$];
  int          n_vec  = 0;
  int          n_miss = 0;
  int          vec_id = 0;
  exp_t        mon_e;
  logic        mon_bad;
  exp_t        x;

  always #5 clk = ~clk;

  fetch_stage #(
    .RESET_PC   (32'h0000_0000),
    .IMEM_DEPTH (32),
    .NOP_INSTR  (32'h0000_0013)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .PCF        (PCF),
    .InstrF     (InstrF),
    .StallF     (StallF),
    .StallD     (StallD),
    .FlushD     (FlushD),
    .PCSrcE     (PCSrcE),
    .PCTargetE  (PCTargetE),
    .InstrD     (InstrD),
    .PCD        (PCD),
    .PCPlus4D   (PCPlus4D),
    .ValidD     (ValidD),
    .Halted     (Halted),
    .FetchFault (FetchFault),
    .CycleCnt   (CycleCnt),
    .FetchCnt   (FetchCnt),
    .StallCnt   (StallCnt),
    .FlushCnt   (FlushCnt)
  );

  // Combinational instruction memory; out-of-range reads return 0.
  always_comb begin
    if (PCF[31:2] < 30'd32) InstrF = mem[PCF[6:2]];
    else                    InstrF = 32'h0;
  end

  function automatic exp_t mk(input logic [31:0] pcf, instrd, pcd, p4,
                              input logic v, h, f);
    exp_t e;
    e.id = 0; e.pcf = pcf; e.instrd = instrd; e.pcd = pcd; e.p4 = p4;
    e.v = v; e.h = h; e.f = f;
    e.chk_cnt = 1'b0; e.cyc = '0; e.fet = '0; e.stl = '0; e.fls = '0;
    return e;
  endfunction

  function automatic exp_t bub(input logic [31:0] pcf, input logic h, f);
    return mk(pcf, 32'h0000_0013, 32'h0, 32'h0, 1'b0, h, f);
  endfunction

  task automatic step(input logic r, sf, sd, fd, ps, input logic [31:0] tgt,
                      input exp_t e);
    @(negedge clk);
    rst = r; StallF = sf; StallD = sd; FlushD = fd; PCSrcE = ps; PCTargetE = tgt;
    e.id = vec_id;
    vec_id++;
    sb.push_back(e);
  endtask

  always @(posedge clk) begin
    #1;
    if (sb.size() != 0) begin
      mon_e = sb.pop_front();
      mon_bad = (PCF !== mon_e.pcf) || (InstrD !== mon_e.instrd) ||
                (PCD !== mon_e.pcd) || (PCPlus4D !== mon_e.p4) ||
                (ValidD !== mon_e.v) || (Halted !== mon_e.h) ||
                (FetchFault !== mon_e.f);
`ifdef FETCH_PERF_CNT_EN
      if (mon_e.chk_cnt)
        mon_bad = mon_bad || (CycleCnt !== mon_e.cyc) || (FetchCnt !== mon_e.fet) ||
                  (StallCnt !== mon_e.stl) || (FlushCnt !== mon_e.fls);
`else
      mon_e.chk_cnt = 1'b1;
      mon_bad = mon_bad || ((CycleCnt | FetchCnt | StallCnt | FlushCnt) !== 32'h0);
`endif
      n_vec++;
      if (mon_bad) begin
        n_miss++;
        $display("FAIL vec%0d: got PCF=%h InstrD=%h PCD=%h PCPlus4D=%h V=%b H=%b FF=%b cnt=%0d/%0d/%0d/%0d; want PCF=%h InstrD=%h PCD=%h PCPlus4D=%h V=%b H=%b FF=%b cnt(chk=%b)=%0d/%0d/%0d/%0d",
                 mon_e.id, PCF, InstrD, PCD, PCPlus4D, ValidD, Halted, FetchFault,
                 CycleCnt, FetchCnt, StallCnt, FlushCnt,
                 mon_e.pcf, mon_e.instrd, mon_e.pcd, mon_e.p4, mon_e.v, mon_e.h, mon_e.f,
                 mon_e.chk_cnt, mon_e.cyc, mon_e.fet, mon_e.stl, mon_e.fls);
      end
    end
  end

  initial begin
    for (int unsigned i = 0; i < 32; i++) mem[i] = 32'h0000_0013;
    mem[1] = 32'h00A0_0093;
    mem[2] = 32'h0020_0113;
    mem[3] = 32'h0030_0193;
    mem[4] = 32'h0040_0213;
    mem[5] = 32'h0010_0073;

    // reset, sequential fetch, stall, release
    step(1, 0, 0, 0, 0, 32'h0, bub(32'h0, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h4, 32'h13, 32'h0, 32'h4, 1, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h8, 32'h00A00093, 32'h4, 32'h8, 1, 0, 0));
    step(0, 1, 1, 0, 0, 32'h0, mk(32'h8, 32'h00A00093, 32'h4, 32'h8, 1, 0, 0));
    step(0, 1, 1, 0, 0, 32'h0, mk(32'h8, 32'h00A00093, 32'h4, 32'h8, 1, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'hC, 32'h00200113, 32'h8, 32'hC, 1, 0, 0));
    // redirect overrides StallF, target aligned; flush bubbles
    step(0, 1, 0, 1, 1, 32'h16, bub(32'h14, 0, 0));
    // EBREAK passes to D then halts
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h18, 32'h00100073, 32'h14, 32'h18, 1, 1, 0));
    step(0, 0, 0, 0, 0, 32'h0, bub(32'h18, 1, 0));
    step(0, 0, 0, 0, 1, 32'h4, bub(32'h4, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h8, 32'h00A00093, 32'h4, 32'h8, 1, 0, 0));
    // out-of-range fetch fault, then reset mid-halt
    step(0, 0, 0, 1, 1, 32'h80, bub(32'h80, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, bub(32'h84, 1, 1));
    step(0, 0, 0, 0, 0, 32'h0, bub(32'h84, 1, 1));
    step(1, 0, 0, 0, 0, 32'h0, bub(32'h0, 0, 0));
    // stalled fault PC: no halt until the stall releases
    step(0, 0, 0, 1, 1, 32'h80, bub(32'h80, 0, 0));
    step(0, 1, 1, 0, 0, 32'h0, bub(32'h80, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, bub(32'h84, 1, 1));
    // redirect beats EBREAK in F; PC wrap at the top of the address space
    step(1, 0, 0, 0, 0, 32'h0, bub(32'h0, 0, 0));
    step(0, 0, 0, 1, 1, 32'h14, bub(32'h14, 0, 0));
    step(0, 0, 0, 1, 1, 32'h9, bub(32'h8, 0, 0));
    step(0, 0, 0, 1, 1, 32'hFFFF_FFFF, bub(32'hFFFF_FFFC, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, bub(32'h0, 1, 1));
    // 10 cycles: 6 fetch, 3 stall, 1 flush
    step(1, 0, 0, 0, 0, 32'h0, bub(32'h0, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h4, 32'h13, 32'h0, 32'h4, 1, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h8, 32'h00A00093, 32'h4, 32'h8, 1, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'hC, 32'h00200113, 32'h8, 32'hC, 1, 0, 0));
    step(0, 1, 1, 0, 0, 32'h0, mk(32'hC, 32'h00200113, 32'h8, 32'hC, 1, 0, 0));
    step(0, 1, 1, 0, 0, 32'h0, mk(32'hC, 32'h00200113, 32'h8, 32'hC, 1, 0, 0));
    step(0, 1, 0, 1, 0, 32'h0, bub(32'hC, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h10, 32'h00300193, 32'hC, 32'h10, 1, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h14, 32'h00400213, 32'h10, 32'h14, 1, 0, 0));
    step(0, 0, 0, 0, 0, 32'h0, mk(32'h18, 32'h00100073, 32'h14, 32'h18, 1, 1, 0));
    x = bub(32'h18, 1, 0);
    x.chk_cnt = 1'b1; x.cyc = 32'd10; x.fet = 32'd6; x.stl = 32'd3; x.fls = 32'd1;
    step(0, 0, 0, 0, 0, 32'h0, x);

    @(negedge clk);
    StallF = 1'b0; StallD = 1'b0; FlushD = 1'b0; PCSrcE = 1'b0;
    for (int i = 0; i < 10 && sb.size() != 0; i++) @(negedge clk);
    if (sb.size() != 0) begin
      n_miss++;
      $display("FAIL drain: %0d expectations never checked, want 0", sb.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage RV32I pipeline.
- Owns the fetch PC register and drives PCF into the instruction memory, which answers combinationally on InstrF in the same cycle.
- Registers the IF/ID pipeline register and handles stall, flush, branch/jump redirect, and a HALT state entered on EBREAK or an out-of-range fetch.
- Sits between the hazard unit/execute stage and the decode stage.

Parameters:
- RESET_PC, 32'h0000_0000, PCF value after reset.
- IMEM_DEPTH, 32, instruction memory size in words; PCF/4 >= IMEM_DEPTH is a fetch fault.
- NOP_INSTR, 32'h0000_0013, bubble instruction (addi x0,x0,0) loaded into InstrD on flush/halt.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  synchronous active-high reset
- PCF  out  32  fetch address to instruction memory
- InstrF  in  32  instruction word returned for PCF, same cycle
- StallF  in  1  hold PCF
- StallD  in  1  hold IF/ID register
- FlushD  in  1  bubble IF/ID register
- PCSrcE  in  1  taken branch/jump in EX
- PCTargetE  in  32  redirect target
- InstrD  out  32  decode-stage instruction
- PCD  out  32  PC of InstrD
- PCPlus4D  out  32  PCD+4
- ValidD  out  1  InstrD is a real fetched instruction
- Halted  out  1  fetch is in HALT
- FetchFault  out  1  sticky, HALT was caused by an out-of-range PC
- CycleCnt, FetchCnt, StallCnt, FlushCnt  out  32 each  performance counters (see Optional Feature)

Behaviour:
- Clock and reset: one clock, clk; synchronous active-high reset, rst.
- Reset values:
  - PCF=RESET_PC, InstrD=NOP_INSTR, PCD=0, PCPlus4D=0, ValidD=0.
  - Halted=0, FetchFault=0, state=RUN, all counters 0.
  - rst asserted mid-operation overrides every other input in that cycle.
- Fetch is combinational: InstrF for PCF is captured into IF/ID at the next edge, so there is 1 cycle from PCF to InstrD.
- PC update, in priority order:
  - rst.
  - PCSrcE: PCF<=PCTargetE. Overrides StallF and HALT. PCTargetE[1:0] is ignored; the value is forced to word alignment.
  - StallF or state=HALT: PCF holds.
  - Otherwise: PCF<=PCF+4, wrapping modulo 2^32.
- IF/ID update, in priority order:
  - rst.
  - FlushD: InstrD=NOP_INSTR, ValidD=0, PCD and PCPlus4D=0. FlushD beats StallD.
  - StallD: all IF/ID fields hold.
  - state=HALT or a fetch fault this cycle: bubble, identical to FlushD.
  - Otherwise: InstrD<=InstrF, PCD<=PCF, PCPlus4D<=PCF+4, ValidD<=1.
- FSM states RUN and HALT:
  - RUN->HALT when InstrF==32'h0010_0073 (EBREAK) is accepted, i.e. !StallF, !PCSrcE, !FlushD. The EBREAK itself is passed into D with ValidD=1.
  - RUN->HALT when PCF[31:2] >= IMEM_DEPTH and !StallF and !PCSrcE. FetchFault<=1 and the faulting word is bubbled, not passed.
  - HALT->RUN only on PCSrcE, because the older branch proves the halt was wrong-path. FetchFault clears on this transition.
  - Halted = (state==HALT), registered.
- Simultaneous events:
  - PCSrcE together with EBREAK in F: redirect wins, no halt.
  - StallF with a fault PC: no halt until the stall releases.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- Defined:
  - CycleCnt increments every non-reset cycle.
  - FetchCnt increments when IF/ID loads a valid instruction.
  - StallCnt increments on StallF && !PCSrcE.
  - FlushCnt increments on FlushD.
  - All four saturate at 32'hFFFF_FFFF and reset to 0.
- Undefined: all four counter ports are tied to 32'h0, with no flops.

Decomposition:
- Package fetch_pkg:
  - NOP_INSTR, EBREAK_INSTR (32'h0010_0073) and RV32 instruction width constants.
  - fetch_state_t enum {RUN, HALT}.
- Sub-module fetch_perf_counters holds the four saturating counters and is instantiated only under FETCH_PERF_CNT_EN.

Test Plan:
- Sequential run: memory loaded 0x0 nop, then 0x00A00093 at word 1, etc. After rst, check PCF = 0, 4, 8, 12 on successive cycles. InstrD=0x00A00093 and PCD=4 one cycle after PCF=4.
- StallF=StallD=1 for 2 cycles at PCF=8: PCF stays 8 and InstrD holds. Release: PCF=12 next cycle.
- PCSrcE=1, PCTargetE=0x16 while StallF=1: PCF=0x14 next cycle. Same cycle with FlushD=1: InstrD=0x13, ValidD=0.
- EBREAK at word 5 (PCF=20): InstrD=0x00100073 with ValidD=1, Halted=1, and PCF stays 24. Bubbles follow. PCSrcE to 0x4 returns RUN and PCF=4.
- PCTargetE=0x80 (word 32, IMEM_DEPTH=32): FetchFault=1, Halted=1, ValidD=0. Assert rst mid-halt: all outputs return to reset values next edge.
- With FETCH_PERF_CNT_EN: 10 cycles containing 3 stall, 1 flush and 6 fetch cycles give CycleCnt=10, StallCnt=3, FlushCnt=1, FetchCnt=6. Without the macro all four read 0.
